// File: rtl/gba_cart_rom_slave_if.sv
// Memory read/write port between the GBA cartridge bus slave and its ROM storage.
// master = bus slave block driving the memory, slave = memory side.
interface gba_cart_rom_slave_if #(
   parameter int ROM_AW = 12
);
   logic [ROM_AW-1:0] mem_addr;
   logic              mem_rd;
   logic [15:0]       mem_rdata;
   logic              mem_wr;
   logic [15:0]       mem_wdata;

   modport master (
      output mem_addr, mem_rd, mem_wr, mem_wdata,
      input  mem_rdata
   );

   modport slave (
      input  mem_addr, mem_rd, mem_wr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/gba_cart_rom_slave.sv
// GBA cartridge ROM-bus slave: latches the muxed halfword address, prefetches from
// a sync memory port and bursts on /RD rise. Define GBA_CART_WR_EN to add cart writes.
module gba_cart_rom_slave #(
   parameter int ROM_AW     = 12,
   parameter int MEM_LAT    = 1,
   parameter int ACT_CYCLES = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        cart_cs_n,
   input  logic                        cart_rd_n,
   input  logic                        cart_wr_n,
   input  logic [7:0]                  cart_ah,
   input  logic [15:0]                 ad_in,
   output logic [15:0]                 ad_out,
   output logic                        ad_oe,
   gba_cart_rom_slave_if.master        mem,
   output logic                        act,
   output logic                        underrun
);

   localparam int ACT_W = $clog2(ACT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, FETCH, READY} state_e;

   // Pin vector: bit 0 = /CS, bit 1 = /RD, bit 2 = /WR (write build only).
`ifdef GBA_CART_WR_EN
   localparam int NP = 3;
   logic [NP-1:0] pin_raw;
   assign pin_raw = {cart_wr_n, cart_rd_n, cart_cs_n};
`else
   localparam int NP = 2;
   logic [NP-1:0] pin_raw;
   logic          wr_unused;
   assign pin_raw   = {cart_rd_n, cart_cs_n};
   assign wr_unused = cart_wr_n;
`endif

   logic [NP-1:0] s0_q, s0_d, s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
   logic [NP-1:0] rise_q, rise_d, fall_q, fall_d;

   state_e            state_q, state_d;
   logic [23:0]       addr_q, addr_d;
   logic [15:0]       ad_out_q, ad_out_d;
   logic [1:0]        lat_q, lat_d;
   logic              underrun_q, underrun_d;
   logic [ACT_W-1:0]  act_cnt_q, act_cnt_d;
   logic              rd_strobe, wr_strobe;
   logic              in_range;
   logic              cs_rise, cs_fall, rd_rise, rd_fall, wr_rise, wr_fall;
   logic [15:0]       wdata_q, wdata_d;

   assign cs_rise = rise_q[0];
   assign cs_fall = fall_q[0];
   assign rd_rise = rise_q[1];
   assign rd_fall = fall_q[1];
`ifdef GBA_CART_WR_EN
   assign wr_rise = rise_q[2];
   assign wr_fall = fall_q[2];
`else
   assign wr_rise = 1'b0;
   assign wr_fall = 1'b0;
`endif

   assign in_range = (addr_q[23:ROM_AW] == '0);

   // Three synchroniser stages, a delay stage and registered edges: 4 clk pin-to-event.
   always_comb begin
      s0_d   = pin_raw;
      s1_d   = s0_q;
      s2_d   = s1_q;
      s3_d   = s2_q;
      rise_d = ~s3_q & s2_q;
      fall_d = s3_q & ~s2_q;
   end

   // NOTE: every output of this block gets a default first, so no latch is inferred
   // on paths that do not assign it.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      ad_out_d  = ad_out_q;
      lat_d     = lat_q;
      rd_strobe = 1'b0;
      wr_strobe = 1'b0;

      if (cs_rise) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: if (cs_fall) begin
               addr_d  = {cart_ah, ad_in};
               lat_d   = '0;
               state_d = FETCH;
            end
            FETCH: begin
               rd_strobe = (lat_q == 2'd0);
               if (lat_q == 2'(MEM_LAT)) begin
                  ad_out_d = in_range ? mem.mem_rdata : addr_q[15:0];
                  state_d  = READY;
               end else begin
                  lat_d = lat_q + 2'd1;
               end
            end
            READY: if (rd_rise) begin
               addr_d  = addr_q + 24'd1;
               lat_d   = '0;
               state_d = FETCH;
            end else if (wr_rise) begin
               wr_strobe = in_range;
               addr_d    = addr_q + 24'd1;
               lat_d     = '0;
               state_d   = FETCH;
            end
            default: state_d = IDLE;
         endcase
      end

      underrun_d = underrun_q | (rd_fall & ~cs_rise & (state_q == FETCH));

      if (rd_fall || wr_fall)
         act_cnt_d = ACT_W'(ACT_CYCLES);
      else if (act_cnt_q != '0)
         act_cnt_d = act_cnt_q - 1'b1;
      else
         act_cnt_d = act_cnt_q;
   end

`ifdef GBA_CART_WR_EN
   // Track the AD bus while the cart holds /WR and /CS low; the last value is written.
   always_comb begin
      wdata_d = (~s2_q[2] & ~s2_q[0]) ? ad_in : wdata_q;
   end
`else
   always_comb begin
      wdata_d = '0;
   end
`endif

   // NOTE: sequential state uses non-blocking assignments so all flops sample
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s0_q       <= '1;
         s1_q       <= '1;
         s2_q       <= '1;
         s3_q       <= '1;
         rise_q     <= '0;
         fall_q     <= '0;
         state_q    <= IDLE;
         addr_q     <= '0;
         ad_out_q   <= '0;
         lat_q      <= '0;
         underrun_q <= 1'b0;
         act_cnt_q  <= '0;
         wdata_q    <= '0;
      end else begin
         s0_q       <= s0_d;
         s1_q       <= s1_d;
         s2_q       <= s2_d;
         s3_q       <= s3_d;
         rise_q     <= rise_d;
         fall_q     <= fall_d;
         state_q    <= state_d;
         addr_q     <= addr_d;
         ad_out_q   <= ad_out_d;
         lat_q      <= lat_d;
         underrun_q <= underrun_d;
         act_cnt_q  <= act_cnt_d;
         wdata_q    <= wdata_d;
      end
   end

   // Strobes are gated by rst_n so a reset landing mid-burst never issues one.
   assign mem.mem_addr  = addr_q[ROM_AW-1:0];
   assign mem.mem_rd    = rst_n & rd_strobe;
   assign mem.mem_wr    = rst_n & wr_strobe;
   assign mem.mem_wdata = wdata_q;

   assign ad_out   = ad_out_q;
   assign ad_oe    = rst_n & ~cart_cs_n & ~cart_rd_n;
   assign act      = (act_cnt_q != '0);
   assign underrun = underrun_q;

endmodule

// File: tb/tb_gba_cart_rom_slave.sv
// Directed bench for gba_cart_rom_slave: ROM_AW=12, MEM_LAT=2, memory holds k^0xA5A5.
`timescale 1ns/1ps
module tb_gba_cart_rom_slave;
   localparam int ROM_AW     = 12;
   localparam int MEM_LAT    = 2;
   localparam int ACT_CYCLES = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cart_cs_n = 1'b1;
   logic        cart_rd_n = 1'b1;
   logic        cart_wr_n = 1'b1;
   logic [7:0]  cart_ah = 8'h00;
   logic [15:0] ad_in = 16'h0000;
   logic [15:0] ad_out;
   logic        ad_oe;
   logic        act;
   logic        underrun;

   int n_vec  = 0;
   int n_miss = 0;

   logic [ROM_AW-1:0] rd_log[$];
   logic [ROM_AW-1:0] wr_addr_log[$];
   logic [15:0]       wr_data_log[$];

   logic [15:0] stage1_q = 16'h0000;
   logic [15:0] rdata_q  = 16'h0000;

   gba_cart_rom_slave_if #(.ROM_AW(ROM_AW)) mem_if ();

   gba_cart_rom_slave #(
      .ROM_AW    (ROM_AW),
      .MEM_LAT   (MEM_LAT),
      .ACT_CYCLES(ACT_CYCLES)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cart_cs_n(cart_cs_n),
      .cart_rd_n(cart_rd_n),
      .cart_wr_n(cart_wr_n),
      .cart_ah  (cart_ah),
      .ad_in    (ad_in),
      .ad_out   (ad_out),
      .ad_oe    (ad_oe),
      .mem      (mem_if),
      .act      (act),
      .underrun (underrun)
   );

   always #5 clk = ~clk;

   // Two-stage sync memory: data for a read issued in cycle t is visible in cycle t+2.
   always @(posedge clk) begin
      if (mem_if.mem_rd) stage1_q <= 16'(mem_if.mem_addr) ^ 16'hA5A5;
      rdata_q <= stage1_q;
   end
   assign mem_if.mem_rdata = rdata_q;

   always @(negedge clk) begin
      if (mem_if.mem_rd) rd_log.push_back(mem_if.mem_addr);
      if (mem_if.mem_wr) begin
         wr_addr_log.push_back(mem_if.mem_addr);
         wr_data_log.push_back(mem_if.mem_wdata);
      end
   end

   task automatic clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_miss++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One /RD pulse, 8 clk low then 8 clk high; the word is checked just before /RD rises.
   task automatic rd_pulse(input string tag, input logic [15:0] exp);
      cart_rd_n = 1'b0;
      clks(8);
      check(tag, 32'(ad_out), 32'(exp));
      cart_rd_n = 1'b1;
      clks(8);
   endtask

   task automatic cs_open(input logic [7:0] ah, input logic [15:0] ad);
      cart_ah   = ah;
      ad_in     = ad;
      cart_cs_n = 1'b0;
      rd_log.delete();
   endtask

   initial begin
      // Reset with idle pins, then /CS and /RD low while still in reset.
      clks(3);
      check("rst_ad_out",    32'(ad_out),           32'h0);
      check("rst_ad_oe",     32'(ad_oe),            32'h0);
      check("rst_mem_addr",  32'(mem_if.mem_addr), 32'h0);
      check("rst_mem_rd",    32'(mem_if.mem_rd),   32'h0);
      check("rst_mem_wr",    32'(mem_if.mem_wr),   32'h0);
      check("rst_mem_wdata", 32'(mem_if.mem_wdata),32'h0);
      check("rst_act",       32'(act),              32'h0);
      check("rst_underrun",  32'(underrun),         32'h0);
      cart_cs_n = 1'b0;
      cart_rd_n = 1'b0;
      #1;
      check("rst_ad_oe_cs_low", 32'(ad_oe), 32'h0);
      cart_cs_n = 1'b1;
      cart_rd_n = 1'b1;
      clks(1);
      rst_n = 1'b1;
      clks(6);

      // In-range burst from 0x000010.
      cs_open(8'h00, 16'h0010);
      clks(10);
      cart_rd_n = 1'b0;
      clks(8);
      check("burst_ad_oe", 32'(ad_oe),  32'h1);
      check("burst_act",   32'(act),    32'h1);
      check("burst_rd0",   32'(ad_out), 32'hA5B5);
      cart_rd_n = 1'b1;
      clks(8);
      rd_pulse("burst_rd1", 16'hA5B4);
      rd_pulse("burst_rd2", 16'hA5B7);
      rd_pulse("burst_rd3", 16'hA5B6);
      cart_cs_n = 1'b1;
      clks(8);
      check("burst_fetch_cnt", 32'(rd_log.size()), 32'd5);
      check("burst_maddr0", 32'(rd_log[0]), 32'h010);
      check("burst_maddr1", 32'(rd_log[1]), 32'h011);
      check("burst_maddr2", 32'(rd_log[2]), 32'h012);
      check("burst_maddr3", 32'(rd_log[3]), 32'h013);
      check("burst_act_idle", 32'(act), 32'h0);
      check("burst_ad_oe_idle", 32'(ad_oe), 32'h0);

      // Out-of-range address returns open-bus halfword.
      cs_open(8'h01, 16'h2345);
      clks(10);
      rd_pulse("oor_rd0", 16'h2345);
      rd_pulse("oor_rd1", 16'h2346);
      cart_cs_n = 1'b1;
      clks(8);
      check("oor_maddr0", 32'(rd_log[0]), 32'h345);
      check("oor_underrun", 32'(underrun), 32'h0);

      // 24-bit wrap from 0xFFFFFF to 0x000000.
      cs_open(8'hFF, 16'hFFFF);
      clks(10);
      rd_pulse("wrap_rd0", 16'hFFFF);
      rd_pulse("wrap_rd1", 16'hA5A5);
      cart_cs_n = 1'b1;
      clks(8);
      check("wrap_maddr0", 32'(rd_log[0]), 32'hFFF);
      check("wrap_maddr1", 32'(rd_log[1]), 32'h000);
      check("wrap_underrun", 32'(underrun), 32'h0);

      // /WR pulse at 0x000040 with AD=0xBEEF.
      wr_addr_log.delete();
      wr_data_log.delete();
      cs_open(8'h00, 16'h0040);
      clks(10);
      check("wr_pre_ad_out", 32'(ad_out), 32'hA5E5);
      ad_in     = 16'hBEEF;
      cart_wr_n = 1'b0;
      clks(8);
      cart_wr_n = 1'b1;
      clks(10);
`ifdef GBA_CART_WR_EN
      check("wr_count",    32'(wr_addr_log.size()), 32'd1);
      check("wr_addr",     32'(wr_addr_log[0]),     32'h040);
      check("wr_data",     32'(wr_data_log[0]),     32'hBEEF);
      check("wr_next_cnt", 32'(rd_log.size()),      32'd2);
      check("wr_next_addr",32'(rd_log[1]),          32'h041);
      check("wr_next_data",32'(ad_out),             32'hA5E4);
`else
      check("wr_count",    32'(wr_addr_log.size()),   32'd0);
      check("wr_wdata",    32'(mem_if.mem_wdata),     32'h0);
      check("wr_fetch_cnt",32'(rd_log.size()),        32'd1);
      check("wr_ad_out",   32'(ad_out),               32'hA5E5);
`endif
      cart_cs_n = 1'b1;
      clks(8);

      // /RD falls two clocks after /CS: underrun, sticky across /CS rise.
      cs_open(8'h00, 16'h0100);
      clks(2);
      cart_rd_n = 1'b0;
      clks(8);
      check("udr_set", 32'(underrun), 32'h1);
      check("udr_data", 32'(ad_out), 32'hA4A5);
      cart_rd_n = 1'b1;
      clks(10);
      check("udr_next_data", 32'(ad_out), 32'hA4A4);
      cart_cs_n = 1'b1;
      clks(8);
      check("udr_sticky", 32'(underrun), 32'h1);

      // /CS rises while the first fetch is in flight: fetch dropped, ad_out kept.
      cs_open(8'h00, 16'h0200);
      clks(2);
      cart_cs_n = 1'b1;
      clks(12);
      check("abort_fetch_cnt", 32'(rd_log.size()), 32'd1);
      check("abort_maddr",     32'(rd_log[0]),     32'h200);
      check("abort_ad_out",    32'(ad_out),        32'hA4A4);
      check("abort_underrun",  32'(underrun),      32'h1);

      // Reset clears the sticky flag and the data latch.
      rst_n = 1'b0;
      clks(3);
      check("rst2_underrun", 32'(underrun), 32'h0);
      check("rst2_ad_out",   32'(ad_out),   32'h0);
      check("rst2_act",      32'(act),      32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
